fight_score_engine: RTL and testbench
=====================================

Name: fight_score_engine

Overview:
Parametrised two-player scoring engine for the boxing game. It takes each player's 2-bit action state and detects punch onsets through synchronised edge detection. On each punch it transfers points from the defender to the attacker. Damage depends on the defender's state, with per-player cooldown, clash handling, a win/over state machine and BCD score outputs for the 7-segment display driver.

Parameters:
INI_POINT, 10, starting points per player; total pool is 2*INI_POINT and is conserved.
DMG_IDLE, 2, damage when defender state is 2'b00.
DMG_GUARD, 1, damage when defender state is 2'b01.
DMG_OPEN, 3, damage when defender state is 2'b10 or 2'b11.
COOLDOWN, 8, cycles after a hit or clash during which that player's new punches are ignored (0 = none).
DIGITS, 2, BCD digits per score output; must cover 2*INI_POINT.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
state1  in  2  player 1 action: 00 idle, 01 guard, 10 windup, 11 punch (asynchronous to clk)
state2  in  2  player 2 action, same encoding
restart  in  1  single-cycle pulse; starts a new bout from OVER
point1_bcd  out  4*DIGITS  player 1 score, BCD, least-significant digit in [3:0]
point2_bcd  out  4*DIGITS  player 2 score, BCD
win  out  1  high while in OVER
winner  out  1  0 = player 1 won, 1 = player 2 won; valid when win=1
hit1  out  1  one-cycle pulse when a player-1 punch lands
hit2  out  1  one-cycle pulse when a player-2 punch lands
clash  out  1  one-cycle pulse when both punches land in the same cycle

Behaviour:
- Clock, reset, and reset values: one clock, clk; reset rst is asynchronous, active-low.
  - On reset: points = INI_POINT each; FSM = FIGHT; cooldowns = 0; sync/prev registers = 2'b00.
  - On reset outputs are: win=0, winner=0, hit1/hit2/clash=0, pointN_bcd = BCD(INI_POINT), e.g. 8'h10.
  - Reset asserted mid-bout or in OVER aborts immediately to these values.
- Input conditioning, per player:
  - Two-flop synchroniser s1→s2, then prev register s3.
  - Punch onset evN = (s2==2'b11) && (s3!=2'b11) && (cdN==0) && FSM==FIGHT.
  - Holding 11 produces exactly one onset. An onset during cooldown is dropped, not queued.
- Latency:
  - An input change captured at edge k reaches s2 at edge k+1.
  - Points, hit pulses and FSM update at edge k+2.
  - BCD outputs update at edge k+3.
- Defender state: the defender's s2 value in the onset cycle selects DMG_IDLE, DMG_GUARD or DMG_OPEN.
- Single onset (ev1 xor ev2), for attacker A and defender D:
  - If pointD > dmg: pointD -= dmg, pointA += dmg; hitA pulses; cdA loads COOLDOWN.
  - Else (pointD <= dmg): pointD = 0, pointA = 2*INI_POINT; hitA pulses; FSM → OVER; winner = A.
- Simultaneous onsets (ev1 && ev2): no point change; clash pulses; cd1 and cd2 both load COOLDOWN.
- Cooldown counters decrement by 1 per cycle while nonzero and saturate at 0.
- FSM:
  - FIGHT: evaluate onsets as above.
  - OVER: win=1, points frozen, onsets ignored, cooldowns cleared.
  - restart in OVER: points ← INI_POINT, cooldowns ← 0, win ← 0, FSM → FIGHT on the next edge.
  - restart in FIGHT is ignored.
- Arithmetic:
  - Point registers are $clog2(2*INI_POINT+1) bits, unsigned.
  - The transfer never under- or overflows, because the total pool is conserved.
- BCD: binary-to-BCD of each point register, registered. No leading-digit blanking; that belongs to the display driver.

Decomposition:
- Shared package fight_pkg:
  - State encoding constants ST_IDLE, ST_GUARD, ST_WIND, ST_PUNCH.
  - FSM enum {FIGHT, OVER}.
  - Function dmg_of(state) returning the parameter-selected damage.
- One sub-module, score_bcd:
  - Combinational double-dabble, parameterised by input width and DIGITS.
  - Instantiated twice.
  - Output register sits in fight_score_engine.

Test Plan:
- Reset, then idle 20 cycles -> point1_bcd=8'h10, point2_bcd=8'h10, win=0, no pulses.
- state2=01 held; state1 00→11 for 5 cycles, then 00 -> exactly one hit1, pulsing 2 cycles after the input sample; scores 11/09 (8'h11/8'h09).
- Player 1 punches at 3-cycle spacing with COOLDOWN=8 -> only the first lands; after cooldown expires the next onset lands.
- state1 and state2 both 00→11 on the same edge -> clash pulse, scores stay 10/10, both cooldowns load.
- Player 2 at 2 points; state2=10; player 1 punches -> point2=0, point1=20 (8'h20), win=1, winner=0. Further punches are ignored; restart pulse -> 10/10, win=0.
- Reset asserted mid-cooldown and while win=1 -> all outputs return to reset values asynchronously. A punch immediately after reset release lands with no stale cooldown.

Source files
------------

// File: rtl/fight_pkg.sv
// Shared definitions for the two-player fight scoring engine:
// action encodings, bout FSM states and the defender-state damage lookup.
package fight_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GUARD = 2'b01;
    localparam logic [1:0] ST_WIND  = 2'b10;
    localparam logic [1:0] ST_PUNCH = 2'b11;

    typedef enum logic {
        FIGHT = 1'b0,
        OVER  = 1'b1
    } fsm_t;

    // Damage taken by a defender sitting in state st.
    function automatic int unsigned dmg_of(
        input logic [1:0]  st,
        input int unsigned d_idle,
        input int unsigned d_guard,
        input int unsigned d_open
    );
        case (st)
            ST_IDLE:            return d_idle;
            ST_GUARD:           return d_guard;
            ST_WIND, ST_PUNCH:  return d_open;
            default:            return d_open;
        endcase
    endfunction

endpackage

// File: rtl/score_bcd.sv
// Combinational binary-to-BCD converter (double-dabble) for one score value.
module score_bcd #(
    parameter int unsigned W      = 5,
    parameter int unsigned DIGITS = 2
) (
    input  logic [W-1:0]          bin,
    output logic [4*DIGITS-1:0]   bcd
);

    logic [4*DIGITS-1:0] acc;

    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < W; i++) begin
            for (int unsigned d = 0; d < DIGITS; d++) begin
                if (acc[4*d +: 4] >= 4'd5)
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
            acc = {acc[4*DIGITS-2:0], bin[W-1-i]};
        end
        bcd = acc;
    end

endmodule

// File: rtl/fight_score_engine.sv
// Two-player boxing score engine: synchronised punch-onset detection, point
// transfer by defender state, per-player cooldown, clash and KO handling.
module fight_score_engine
    import fight_pkg::*;
#(
    parameter int unsigned INI_POINT = 10,
    parameter int unsigned DMG_IDLE  = 2,
    parameter int unsigned DMG_GUARD = 1,
    parameter int unsigned DMG_OPEN  = 3,
    parameter int unsigned COOLDOWN  = 8,
    parameter int unsigned DIGITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            state1,
    input  logic [1:0]            state2,
    input  logic                  restart,
    output logic [4*DIGITS-1:0]   point1_bcd,
    output logic [4*DIGITS-1:0]   point2_bcd,
    output logic                  win,
    output logic                  winner,
    output logic                  hit1,
    output logic                  hit2,
    output logic                  clash
);

    localparam int unsigned POOL = 2 * INI_POINT;
    localparam int unsigned PW   = $clog2(POOL + 1);
    localparam int unsigned CW   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [PW-1:0] INI_P   = PW'(INI_POINT);
    localparam logic [PW-1:0] POOL_P  = PW'(POOL);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);

    function automatic logic [4*DIGITS-1:0] ini_bcd(input int unsigned v);
        int unsigned r;
        r = v;
        ini_bcd = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            ini_bcd[4*d +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    localparam logic [4*DIGITS-1:0] INI_BCD = ini_bcd(INI_POINT);

    fsm_t fsm, fsm_nxt;

    logic [1:0]    p1_s1, p1_s2, p1_s3;
    logic [1:0]    p2_s1, p2_s2, p2_s3;
    logic [PW-1:0] pt1, pt2;
    logic [CW-1:0] cd1, cd2;
    logic [PW-1:0] dmg_to1, dmg_to2;
    logic          ev1, ev2, ko1, ko2;
    logic [4*DIGITS-1:0] bcd1_c, bcd2_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_s1 <= '0; p1_s2 <= '0; p1_s3 <= '0;
            p2_s1 <= '0; p2_s2 <= '0; p2_s3 <= '0;
        end else begin
            p1_s1 <= state1; p1_s2 <= p1_s1; p1_s3 <= p1_s2;
            p2_s1 <= state2; p2_s2 <= p2_s1; p2_s3 <= p2_s2;
        end
    end

    // Damage is chosen by the defender's synchronised state in the onset cycle.
    assign dmg_to2 = PW'(dmg_of(p2_s2, DMG_IDLE, DMG_GUARD, DMG_OPEN));
    assign dmg_to1 = PW'(dmg_of(p1_s2, DMG_IDLE, DMG_GUARD, DMG_OPEN));

    assign ev1 = (p1_s2 == ST_PUNCH) && (p1_s3 != ST_PUNCH) && (cd1 == '0) && (fsm == FIGHT);
    assign ev2 = (p2_s2 == ST_PUNCH) && (p2_s3 != ST_PUNCH) && (cd2 == '0) && (fsm == FIGHT);
    assign ko1 = ev1 && !ev2 && (pt2 <= dmg_to2);
    assign ko2 = ev2 && !ev1 && (pt1 <= dmg_to1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fsm <= FIGHT;
        else
            fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            FIGHT:   if (ko1 || ko2) fsm_nxt = OVER;
            OVER:    if (restart)    fsm_nxt = FIGHT;
            default: fsm_nxt = FIGHT;
        endcase
    end

    always_comb begin
        win = (fsm == OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pt1    <= INI_P;
            pt2    <= INI_P;
            cd1    <= '0;
            cd2    <= '0;
            hit1   <= 1'b0;
            hit2   <= 1'b0;
            clash  <= 1'b0;
            winner <= 1'b0;
        end else begin
            hit1  <= 1'b0;
            hit2  <= 1'b0;
            clash <= 1'b0;
            if (fsm == OVER) begin
                cd1 <= '0;
                cd2 <= '0;
                if (restart) begin
                    pt1 <= INI_P;
                    pt2 <= INI_P;
                end
            end else begin
                cd1 <= (cd1 != '0) ? cd1 - 1'b1 : '0;
                cd2 <= (cd2 != '0) ? cd2 - 1'b1 : '0;
                if (ev1 && ev2) begin
                    clash <= 1'b1;
                    cd1   <= CD_LOAD;
                    cd2   <= CD_LOAD;
                end else if (ev1) begin
                    hit1 <= 1'b1;
                    cd1  <= CD_LOAD;
                    if (ko1) begin
                        pt2    <= '0;
                        pt1    <= POOL_P;
                        winner <= 1'b0;
                    end else begin
                        pt2 <= pt2 - dmg_to2;
                        pt1 <= pt1 + dmg_to2;
                    end
                end else if (ev2) begin
                    hit2 <= 1'b1;
                    cd2  <= CD_LOAD;
                    if (ko2) begin
                        pt1    <= '0;
                        pt2    <= POOL_P;
                        winner <= 1'b1;
                    end else begin
                        pt1 <= pt1 - dmg_to1;
                        pt2 <= pt2 + dmg_to1;
                    end
                end
            end
        end
    end

    score_bcd #(.W(PW), .DIGITS(DIGITS)) u_bcd1 (.bin(pt1), .bcd(bcd1_c));
    score_bcd #(.W(PW), .DIGITS(DIGITS)) u_bcd2 (.bin(pt2), .bcd(bcd2_c));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            point1_bcd <= INI_BCD;
            point2_bcd <= INI_BCD;
        end else begin
            point1_bcd <= bcd1_c;
            point2_bcd <= bcd2_c;
        end
    end

endmodule

// File: tb/tb_fight_score_engine.sv
// Directed self-checking bench for fight_score_engine.
module tb_fight_score_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state1, state2;
    logic       restart;
    logic [7:0] point1_bcd, point2_bcd;
    logic       win, winner, hit1, hit2, clash;

    int n_cmp = 0;
    int n_bad = 0;
    int n_h1 = 0, n_h2 = 0, n_cl = 0;
    int b1, b2, bc;

    fight_score_engine #(
        .INI_POINT(10), .DMG_IDLE(2), .DMG_GUARD(1), .DMG_OPEN(3),
        .COOLDOWN(8), .DIGITS(2)
    ) dut (
        .clk(clk), .rst(rst), .state1(state1), .state2(state2), .restart(restart),
        .point1_bcd(point1_bcd), .point2_bcd(point2_bcd),
        .win(win), .winner(winner), .hit1(hit1), .hit2(hit2), .clash(clash)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hit1 === 1'b1) n_h1++;
        if (hit2 === 1'b1) n_h2++;
        if (clash === 1'b1) n_cl++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic punch1();
        state1 = 2'b11; tick(); state1 = 2'b00;
    endtask

    task automatic punch2();
        state2 = 2'b11; tick(); state2 = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b0; tick(); rst = 1'b1;
    endtask

    task automatic check_scores(input string tag, input logic [7:0] e1, input logic [7:0] e2);
        check({tag, "_p1"}, point1_bcd, e1);
        check({tag, "_p2"}, point2_bcd, e2);
    endtask

    initial begin
        rst = 1'b1; state1 = 2'b00; state2 = 2'b00; restart = 1'b0;
        #2 rst = 1'b0;
        tick(2);
        check_scores("in_reset", 8'h10, 8'h10);
        check("in_reset_win", win, 0);
        check("in_reset_winner", winner, 0);
        rst = 1'b1;
        tick(20);
        check_scores("idle", 8'h10, 8'h10);
        check("idle_win", win, 0);
        check("idle_pulses", n_h1 + n_h2 + n_cl, 0);

        restart = 1'b1; tick(); restart = 1'b0; tick(2);
        check("restart_fight_win", win, 0);
        check_scores("restart_fight", 8'h10, 8'h10);

        // Held punch against a guard: one hit, 1 point moves.
        state2 = 2'b01; state1 = 2'b11;
        tick(2);
        check("hit1_early", hit1, 0);
        tick();
        check("hit1_lat", hit1, 1);
        check("bcd_lat_p1", point1_bcd, 8'h10);
        tick();
        check("hit1_one_cycle", hit1, 0);
        check_scores("guard_hit", 8'h11, 8'h09);
        tick();
        state1 = 2'b00;
        tick(12);
        check("hold_one_hit", n_h1, 1);

        // Punches spaced 3 cycles: only the first lands.
        b1 = n_h1;
        punch1(); tick(2); punch1(); tick(2); punch1(); tick(12);
        check("cd_space3", n_h1 - b1, 1);
        check_scores("cd_space3", 8'h12, 8'h08);

        // Spacing 8 falls one cycle inside cooldown.
        b1 = n_h1;
        punch1(); tick(7); punch1(); tick(12);
        check("cd_space8", n_h1 - b1, 1);
        check_scores("cd_space8", 8'h13, 8'h07);

        // Spacing 9 is the first onset after cooldown expiry.
        b1 = n_h1;
        punch1(); tick(8); punch1(); tick(12);
        check("cd_space9", n_h1 - b1, 2);
        check_scores("cd_space9", 8'h15, 8'h05);

        // Clash.
        state2 = 2'b00;
        do_reset();
        b1 = n_h1; b2 = n_h2; bc = n_cl;
        state1 = 2'b11; state2 = 2'b11;
        tick(3);
        check("clash_pulse", clash, 1);
        check("clash_no_hit1", hit1, 0);
        check("clash_no_hit2", hit2, 0);
        state1 = 2'b00; state2 = 2'b00;
        tick();
        check("clash_one_cycle", clash, 0);
        check_scores("clash", 8'h10, 8'h10);
        punch2(); tick(12);
        check("clash_cd2_drop", n_h2 - b2, 0);
        check("clash_count", n_cl - bc, 1);
        check("clash_hit1_count", n_h1 - b1, 0);
        punch2(); tick(12);
        check("p2_after_cd", n_h2 - b2, 1);
        check_scores("p2_idle_hit", 8'h08, 8'h12);

        // Player 1 KO against an open defender.
        do_reset();
        repeat (4) begin punch1(); tick(12); end
        check_scores("pre_ko1", 8'h18, 8'h02);
        check("pre_ko1_win", win, 0);
        state2 = 2'b10; tick(3);
        punch1(); tick(2);
        check("ko1_hit", hit1, 1);
        check("ko1_win", win, 1);
        check("ko1_winner", winner, 0);
        tick();
        check_scores("ko1", 8'h20, 8'h00);
        b1 = n_h1;
        punch1(); tick(5);
        check("over_ignore", n_h1 - b1, 0);
        check_scores("over_frozen", 8'h20, 8'h00);
        check("over_win_held", win, 1);
        restart = 1'b1; tick(); restart = 1'b0;
        check("restart_win", win, 0);
        tick();
        check_scores("restart", 8'h10, 8'h10);
        state2 = 2'b00; tick(3);

        // Player 2 KO where defender points equal the damage.
        repeat (4) begin punch2(); tick(12); end
        check_scores("pre_ko2", 8'h02, 8'h18);
        check("pre_ko2_win", win, 0);
        punch2(); tick(2);
        check("ko2_hit", hit2, 1);
        check("ko2_win", win, 1);
        check("ko2_winner", winner, 1);
        tick();
        check_scores("ko2", 8'h00, 8'h20);

        // Asynchronous reset while in OVER.
        #2 rst = 1'b0;
        #1;
        check("rst_over_win", win, 0);
        check("rst_over_winner", winner, 0);
        check_scores("rst_over", 8'h10, 8'h10);
        tick(); rst = 1'b1;

        // Asynchronous reset mid-cooldown, then an immediate punch.
        punch1(); tick(3);
        check_scores("pre_rst_cd", 8'h12, 8'h08);
        #2 rst = 1'b0;
        #1;
        check_scores("rst_cd", 8'h10, 8'h10);
        check("rst_cd_hit1", hit1, 0);
        tick(); rst = 1'b1;
        b1 = n_h1;
        punch1(); tick(12);
        check("post_rst_punch", n_h1 - b1, 1);
        check_scores("post_rst", 8'h12, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
